// File: rtl/cam_pkg.sv
// Shared types and helpers for the scaled camera capture path.
package cam_pkg;

  // Byte-assembly state: IDLE between lines, B0 waiting for a first byte,
  // B1 waiting for the second byte of a two-byte pixel.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2
  } byte_state_t;

  // Decimation selection as latched at frame start.
  typedef enum logic [1:0] {
    SC1 = 2'd0,
    SC2 = 2'd1,
    SC4 = 2'd2
  } scale_t;

  localparam int STEP_W = 3;

  // Map the raw 2-bit scale pin onto a named scale; code 3 behaves as 1/4.
  function automatic scale_t scale_of(input logic [1:0] raw);
    scale_t sc;
    case (raw)
      2'd0:    sc = SC1;
      2'd1:    sc = SC2;
      default: sc = SC4;
    endcase
    return sc;
  endfunction

  // Pixel/line step size for a given scale.
  function automatic logic [STEP_W-1:0] step_of(input scale_t sc);
    logic [STEP_W-1:0] st;
    case (sc)
      SC1:     st = 3'd1;
      SC2:     st = 3'd2;
      SC4:     st = 3'd4;
      default: st = 3'd4;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/cam_byte_assembler.sv
// Byte FSM and pixel packing. pix_valid is asserted combinationally in the
// cycle whose rising edge samples the last byte of a pixel; the parent
// registers it so the write strobe appears one cycle later.
module cam_byte_assembler
  import cam_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int BYTES_PER_PIX = 2
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              href,
  input  logic [7:0]        din,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data
);

  byte_state_t state_r;
  byte_state_t state_nxt_s;
  logic [7:0]  hi_r;
  logic        first_byte_s;

  // A byte is a "first byte" whenever we are not waiting for a second one;
  // IDLE is included so the byte that raises href is not lost.
  assign first_byte_s = !hold && href && (state_r != B1);

  // State register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: frame sync or a dropped href forces IDLE, which also
  // discards a half-assembled trailing pixel.
  always_comb begin
    state_nxt_s = state_r;
    if (hold || !href) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE, B0: state_nxt_s = (BYTES_PER_PIX == 2) ? B1 : B0;
        B1:       state_nxt_s = B0;
        default:  state_nxt_s = IDLE;
      endcase
    end
  end

  // Hold the most significant byte until its partner arrives.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= 8'h00;
    end else if (first_byte_s) begin
      hi_r <= din;
    end else begin
      hi_r <= hi_r;
    end
  end

  // Output logic: flag a completed pixel and present it zero-extended.
  always_comb begin
    pix_valid = 1'b0;
    pix_data  = {DATA_W{1'b0}};
    if (!hold && href) begin
      if (BYTES_PER_PIX == 2) begin
        if (state_r == B1) begin
          pix_valid = 1'b1;
          pix_data  = DATA_W'({hi_r, din});
        end else begin
          pix_valid = 1'b0;
        end
      end else begin
        pix_valid = 1'b1;
        pix_data  = DATA_W'(din);
      end
    end else begin
      pix_valid = 1'b0;
    end
  end

endmodule

// File: rtl/cam_capture_scaled.sv
// Camera capture with frame-latched enable and 1:1 / 1:2 / 1:4 decimation.
// Produces linear frame-buffer writes clipped to the active window.
module cam_capture_scaled
  import cam_pkg::*;
#(
  parameter int ADDR_W        = 19,
  parameter int DATA_W        = 16,
  parameter int BYTES_PER_PIX = 2,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        din,
  input  logic              cap_en,
  input  logic [1:0]        scale,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              we,
  output logic              frame_done,
  output logic              busy
);

  localparam int X_W   = $clog2(H_ACTIVE + 1) + 3;
  localparam int Y_W   = $clog2(V_ACTIVE + 1) + 3;
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0] LIM1 = CNT_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [CNT_W-1:0] LIM2 = CNT_W'((H_ACTIVE / 2) * (V_ACTIVE / 2));
  localparam logic [CNT_W-1:0] LIM4 = CNT_W'((H_ACTIVE / 4) * (V_ACTIVE / 4));

  logic              vsync_d_r;
  logic              href_d_r;
  logic              en_q_r;
  logic [STEP_W-1:0] step_r;
  logic              synced_r;
  logic [X_W-1:0]    x_r;
  logic [Y_W-1:0]    y_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] dout_r;
  logic              we_r;
  logic              frame_done_r;
  logic              busy_r;

  logic              vs_rise_s;
  logic              href_fall_s;
  logic              pix_valid_s;
  logic [DATA_W-1:0] pix_data_s;
  logic [STEP_W-1:0] mask_s;
  logic [CNT_W-1:0]  limit_s;
  logic [CNT_W-1:0]  addr_next_s;
  logic              wr_ok_s;

  cam_byte_assembler #(
    .DATA_W        (DATA_W),
    .BYTES_PER_PIX (BYTES_PER_PIX)
  ) u_asm (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .hold      (vsync),
    .href      (href),
    .din       (din),
    .pix_valid (pix_valid_s),
    .pix_data  (pix_data_s)
  );

  assign vs_rise_s   = vsync && !vsync_d_r;
  assign href_fall_s = href_d_r && !href;
  assign mask_s      = step_r - 3'd1;

  // If the previous strobe is ending on this edge its address step is
  // folded in, so back-to-back single-byte pixels still get distinct slots.
  assign addr_next_s = {1'b0, addr_r} + {{ADDR_W{1'b0}}, we_r};

  // Frame-buffer capacity for the latched decimation step.
  always_comb begin
    limit_s = LIM4;
    case (step_r)
      3'd1:    limit_s = LIM1;
      3'd2:    limit_s = LIM2;
      default: limit_s = LIM4;
    endcase
  end

  assign wr_ok_s = pix_valid_s && synced_r && en_q_r
                && (x_r < X_W'(H_ACTIVE)) && (y_r < Y_W'(V_ACTIVE))
                && ((x_r[2:0] & mask_s) == 3'd0)
                && ((y_r[2:0] & mask_s) == 3'd0)
                && (addr_next_s < limit_s);

  // Delayed copies of the sync inputs for edge detection.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_r <= 1'b0;
      href_d_r  <= 1'b0;
    end else begin
      vsync_d_r <= vsync;
      href_d_r  <= href;
    end
  end

  // Latch enable and step once per frame so a frame is never mixed.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      en_q_r   <= 1'b0;
      step_r   <= 3'd1;
      synced_r <= 1'b0;
    end else if (vs_rise_s) begin
      en_q_r   <= cap_en;
      step_r   <= step_of(scale_of(scale));
      synced_r <= 1'b1;
    end else begin
      en_q_r   <= en_q_r;
      step_r   <= step_r;
      synced_r <= synced_r;
    end
  end

  // Pixel and line counters; both saturate just past the active window.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
    end else if (vsync) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
    end else begin
      if (href_fall_s) begin
        x_r <= {X_W{1'b0}};
      end else if (pix_valid_s && (x_r != X_W'(H_ACTIVE))) begin
        x_r <= x_r + {{(X_W-1){1'b0}}, 1'b1};
      end else begin
        x_r <= x_r;
      end
      if (href_fall_s && (x_r != {X_W{1'b0}}) && (y_r != Y_W'(V_ACTIVE))) begin
        y_r <= y_r + {{(Y_W-1){1'b0}}, 1'b1};
      end else begin
        y_r <= y_r;
      end
    end
  end

  // Write strobe, data and address; address advances as each strobe ends.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      we_r   <= 1'b0;
      dout_r <= {DATA_W{1'b0}};
      addr_r <= {ADDR_W{1'b0}};
    end else if (vsync) begin
      we_r   <= 1'b0;
      dout_r <= dout_r;
      addr_r <= {ADDR_W{1'b0}};
    end else if (wr_ok_s) begin
      we_r   <= 1'b1;
      dout_r <= pix_data_s;
      addr_r <= addr_next_s[ADDR_W-1:0];
    end else begin
      we_r   <= 1'b0;
      dout_r <= dout_r;
      addr_r <= addr_next_s[ADDR_W-1:0];
    end
  end

  // Busy from the first write; end-of-frame pulse at the next frame sync.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else if (vs_rise_s) begin
      frame_done_r <= busy_r;
      busy_r       <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      busy_r       <= busy_r || wr_ok_s;
    end
  end

  assign addr       = addr_r;
  assign dout       = dout_r;
  assign we         = we_r;
  assign frame_done = frame_done_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_cam_capture_scaled.sv
// Directed and randomised frames against a behavioural capture model.
module tb_cam_capture_scaled;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;
  localparam int HA     = 8;
  localparam int VA     = 4;

  logic              pclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              vsync = 1'b0;
  logic              href = 1'b0;
  logic [7:0]        din = 8'h00;
  logic              cap_en = 1'b0;
  logic [1:0]        scale = 2'd0;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dout;
  logic              we;
  logic              frame_done;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // Stimulus frame: up to 8 lines of up to 32 bytes.
  logic [7:0] fb [0:7][0:31];
  int         flen [0:7];
  int         nlines = 0;

  // Expected writes for the current frame.
  int exp_a[$];
  int exp_d[$];

  // Observed writes (whole run) and bookkeeping.
  int got_a[$];
  int got_d[$];
  int fd_cnt  = 0;
  int we_dbl  = 0;
  bit we_prev = 1'b0;
  int base_a  = 0;
  int base_fd = 0;

  cam_capture_scaled #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .BYTES_PER_PIX (2),
    .H_ACTIVE      (HA),
    .V_ACTIVE      (VA)
  ) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .href       (href),
    .din        (din),
    .cap_en     (cap_en),
    .scale      (scale),
    .addr       (addr),
    .dout       (dout),
    .we         (we),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 pclk = ~pclk;

  // Record write strobes and end-of-frame pulses away from the active edge.
  always @(negedge pclk) begin
    if (we === 1'b1) begin
      got_a.push_back(int'(addr));
      got_d.push_back(int'(dout));
      if (we_prev) we_dbl++;
    end
    if (frame_done === 1'b1) fd_cnt++;
    we_prev = (we === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic vs_pulse(input logic en, input logic [1:0] sc);
    cap_en = en;
    scale  = sc;
    vsync  = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic drive_line(input int l, input int from);
    for (int i = from; i < flen[l]; i++) begin
      din  = fb[l][i];
      href = 1'b1;
      tick();
    end
    href = 1'b0;
    din  = 8'h00;
    repeat (3) tick();
  endtask

  task automatic drive_frame();
    for (int l = 0; l < nlines; l++) begin
      if (flen[l] > 0) drive_line(l, 0);
    end
  endtask

  task automatic load_ramp(input int nl, input int len);
    nlines = nl;
    for (int l = 0; l < 8; l++) begin
      flen[l] = (l < nl) ? len : 0;
      for (int i = 0; i < 32; i++) fb[l][i] = 8'(i);
    end
  endtask

  task automatic load_rand();
    nlines = $urandom_range(0, 7);
    for (int l = 0; l < 8; l++) begin
      flen[l] = (l < nlines) ? $urandom_range(0, 22) : 0;
      for (int i = 0; i < 32; i++) fb[l][i] = 8'($urandom);
    end
  endtask

  // Reference: pixels are byte pairs, y counts lines holding a pixel, and a
  // pixel is kept when inside the window, on the step grid and within the
  // capacity of the decimated buffer.
  task automatic build_expect(input logic en, input logic [1:0] sc);
    int step;
    int lim;
    int cnt;
    int y;
    int np;
    step = (sc == 2'd0) ? 1 : (sc == 2'd1) ? 2 : 4;
    lim  = (HA / step) * (VA / step);
    cnt  = 0;
    y    = 0;
    exp_a.delete();
    exp_d.delete();
    for (int l = 0; l < nlines; l++) begin
      np = flen[l] / 2;
      if (np > 0) begin
        for (int x = 0; x < np; x++) begin
          if (en && x < HA && y < VA && (x % step) == 0 && (y % step) == 0 && cnt < lim) begin
            exp_a.push_back(cnt);
            exp_d.push_back({16'h0, fb[l][2*x], fb[l][2*x+1]});
            cnt++;
          end
        end
        y++;
      end
    end
  endtask

  task automatic mark();
    base_a  = got_a.size();
    base_fd = fd_cnt;
  endtask

  task automatic check_frame(input string tag);
    int n;
    n = got_a.size() - base_a;
    chk({tag, "_nwr"}, n, exp_a.size());
    for (int i = 0; i < exp_a.size() && i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), got_a[base_a+i], exp_a[i]);
      chk($sformatf("%s_data%0d", tag, i), got_d[base_a+i], exp_d[i]);
    end
    chk({tag, "_fd"}, fd_cnt - base_fd, (exp_a.size() > 0) ? 1 : 0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_we1cyc"}, we_dbl, 0);
  endtask

  initial begin
    // Reset values.
    repeat (3) tick();
    chk("rst_addr", addr, 0);
    chk("rst_dout", dout, 0);
    chk("rst_we", we, 1'b0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1:1 capture of a 4x16-byte ramp frame.
    vs_pulse(1'b1, 2'd0);
    load_ramp(4, 16);
    build_expect(1'b1, 2'd0);
    chk("s1_model_n", exp_a.size(), 32);
    chk("s1_model_last", exp_d[31], 32'h0E0F);
    mark();
    drive_frame();
    vs_pulse(1'b1, 2'd1);
    check_frame("s1");

    // 1/2 decimation of the same frame.
    build_expect(1'b1, 2'd1);
    mark();
    drive_frame();
    vs_pulse(1'b1, 2'd0);
    check_frame("s2");

    // Window clipping: 10-pixel lines, 6 lines.
    load_ramp(6, 20);
    build_expect(1'b1, 2'd0);
    mark();
    drive_frame();
    vs_pulse(1'b0, 2'd0);
    check_frame("s3");

    // Disabled frame; enable raised mid-frame has no effect.
    cap_en = 1'b1;
    load_ramp(4, 16);
    build_expect(1'b0, 2'd0);
    mark();
    drive_frame();
    vs_pulse(1'b1, 2'd0);
    check_frame("s4a");
    build_expect(1'b1, 2'd0);
    mark();
    drive_frame();
    vs_pulse(1'b1, 2'd0);
    check_frame("s4b");

    // Reset during line 2, five bytes in: 2 full lines plus 2 pixels written.
    mark();
    drive_line(0, 0);
    drive_line(1, 0);
    for (int i = 0; i < 5; i++) begin
      din  = fb[2][i];
      href = 1'b1;
      tick();
    end
    chk("s5_prewrites", got_a.size() - base_a, 18);
    rst_n = 1'b0;
    tick();
    chk("s5_rst_we", we, 1'b0);
    chk("s5_rst_addr", addr, 0);
    chk("s5_rst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    mark();
    drive_line(2, 5);
    drive_line(3, 0);
    build_expect(1'b0, 2'd0);
    vs_pulse(1'b1, 2'd0);
    check_frame("s5a");
    build_expect(1'b1, 2'd0);
    mark();
    drive_frame();
    vs_pulse(1'b1, 2'd0);
    check_frame("s5b");

    // Odd-byte first line: 3 pixels, then normal pairing resumes.
    load_ramp(4, 16);
    flen[0] = 7;
    build_expect(1'b1, 2'd0);
    chk("s6_model_n", exp_a.size(), 27);
    mark();
    drive_frame();
    vs_pulse(1'b1, 2'd0);
    check_frame("s6");

    // Randomised frames.
    for (int f = 0; f < 6; f++) begin
      logic       en;
      logic [1:0] sc;
      en = ($urandom_range(0, 3) != 0);
      sc = 2'($urandom_range(0, 3));
      vs_pulse(en, sc);
      load_rand();
      build_expect(en, sc);
      mark();
      drive_frame();
      cap_en = ~en;
      scale  = ~sc;
      vs_pulse(1'b0, 2'd0);
      check_frame($sformatf("rnd%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
